// File: rtl/alu_insn_encoder.sv
// alu_insn_encoder
//
// Purpose:
//   Turns {alu_op, operands} requests into RV32I OP / OP-IMM instruction words
//   and streams them into instruction memory, one word per accepted request.
//   This is the inverse of the ALU decode path. The self-test loader uses it
//   to build ALU test programs in IMEM.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous, active-low reset
//   i_start      begin a new program (address/count/illegal flag cleared)
//   i_req_valid  request valid
//   o_req_ready  request accepted when valid & ready
//   i_alu_op     ADD0 SUB1 SLT2 SLTU3 XOR4 OR5 AND6 SLL7 SRL8 SRA9
//   i_use_imm    1: OP-IMM, 0: OP
//   i_rd         destination register
//   i_rs1        source register 1
//   i_rs2        source register 2 (ignored for OP-IMM)
//   i_imm        12-bit immediate (shifts use i_imm[4:0] only)
//   o_wr_en      IMEM write strobe, one cycle per word
//   o_wr_addr    IMEM word address
//   o_wr_data    encoded instruction (holds last value when o_wr_en=0)
//   o_count      words written since i_start
//   o_illegal    sticky: an illegal request was dropped
//   o_full       program reached DEPTH words
module alu_insn_encoder #(
  parameter int ADDR_W    = 11,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 2048
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [3:0]        i_alu_op,
  input  logic              i_use_imm,
  input  logic [4:0]        i_rd,
  input  logic [4:0]        i_rs1,
  input  logic [4:0]        i_rs2,
  input  logic [11:0]       i_imm,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic [ADDR_W:0]   o_count,
  output logic              o_illegal,
  output logic              o_full
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [6:0]        OPC_OP     = 7'b0110011;
  localparam logic [6:0]        OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]        F7_ALT     = 7'b0100000;
  localparam logic [ADDR_W:0]   DEPTH_C    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] BASE_C     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   ONE_C      = (ADDR_W+1)'(1);

  state_t            state;
  state_t            state_next;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic              is_shift;
  logic              op_legal;
  logic [31:0]       insn;
  logic              accept;
  logic              write_go;
  logic [ADDR_W:0]   count_inc;

  // Start wins over a same-cycle request, so the source must hold it.
  assign o_req_ready = (state == RUN) & ~i_start;
  assign accept      = i_req_valid & o_req_ready;
  assign write_go    = accept & op_legal;
  assign count_inc   = o_count + ONE_C;
  assign o_full      = (state == FULL);

  // Instruction encoding. Illegal requests still complete the handshake but
  // never produce a write; SUB has no immediate form, so SUB+imm is illegal.
  always_comb begin
    funct3   = 3'b000;
    funct7   = 7'b0000000;
    is_shift = 1'b0;
    op_legal = 1'b1;
    insn     = 32'd0;
    case (i_alu_op)
      4'd0: funct3 = 3'b000;
      4'd1: begin
        funct3   = 3'b000;
        funct7   = F7_ALT;
        op_legal = ~i_use_imm;
      end
      4'd2: funct3 = 3'b010;
      4'd3: funct3 = 3'b011;
      4'd4: funct3 = 3'b100;
      4'd5: funct3 = 3'b110;
      4'd6: funct3 = 3'b111;
      4'd7: begin
        funct3   = 3'b001;
        is_shift = 1'b1;
      end
      4'd8: begin
        funct3   = 3'b101;
        is_shift = 1'b1;
      end
      4'd9: begin
        funct3   = 3'b101;
        funct7   = F7_ALT;
        is_shift = 1'b1;
      end
      default: op_legal = 1'b0;
    endcase
    if (!i_use_imm) begin
      insn = {funct7, i_rs2, i_rs1, funct3, i_rd, OPC_OP};
    end else if (is_shift) begin
      // Immediate shifts carry funct7 in the upper immediate bits.
      insn = {funct7, i_imm[4:0], i_rs1, funct3, i_rd, OPC_OP_IMM};
    end else begin
      insn = {i_imm, i_rs1, funct3, i_rd, OPC_OP_IMM};
    end
  end

  // Next state: the write that makes count hit DEPTH moves RUN to FULL;
  // start restarts the program from any state.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = IDLE;
      RUN: begin
        if (write_go && (count_inc == DEPTH_C)) begin
          state_next = FULL;
        end
      end
      FULL:    state_next = FULL;
      default: state_next = IDLE;
    endcase
    if (i_start) begin
      state_next = RUN;
    end
  end

  // State and write-port registers. The write strobe, address and data land
  // one cycle after the accept, together with the count increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      o_wr_en   <= 1'b0;
      o_wr_addr <= BASE_C;
      o_wr_data <= 32'd0;
      o_count   <= '0;
      o_illegal <= 1'b0;
    end else begin
      state   <= state_next;
      o_wr_en <= write_go;
      if (i_start) begin
        o_wr_addr <= BASE_C;
        o_count   <= '0;
        o_illegal <= 1'b0;
      end else if (write_go) begin
        o_wr_addr <= BASE_C + o_count[ADDR_W-1:0];
        o_wr_data <= insn;
        o_count   <= count_inc;
      end else if (accept) begin
        o_illegal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_insn_encoder.sv
// tb_alu_insn_encoder
//
// Purpose:
//   Directed bench for alu_insn_encoder (DEPTH=4). Expected IMEM writes are
//   queued when a request is accepted and compared when o_wr_en appears.
module tb_alu_insn_encoder;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 4;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } exp_t;

  logic              clk       = 1'b0;
  logic              rst_n     = 1'b1;
  logic              start     = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [3:0]        alu_op    = 4'd0;
  logic              use_imm   = 1'b0;
  logic [4:0]        rd        = 5'd0;
  logic [4:0]        rs1       = 5'd0;
  logic [4:0]        rs2       = 5'd0;
  logic [11:0]       imm       = 12'd0;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [ADDR_W:0]   count;
  logic              illegal;
  logic              full;

  int   test_count  = 0;
  int   fail_count  = 0;
  int   model_count = 0;
  exp_t sb_queue[$];

  alu_insn_encoder #(
    .ADDR_W   (ADDR_W),
    .BASE_ADDR(0),
    .DEPTH    (DEPTH)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_alu_op   (alu_op),
    .i_use_imm  (use_imm),
    .i_rd       (rd),
    .i_rs1      (rs1),
    .i_rs2      (rs2),
    .i_imm      (imm),
    .o_wr_en    (wr_en),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_count    (count),
    .o_illegal  (illegal),
    .o_full     (full)
  );

  always #5 clk = ~clk;

  // Reference encoder written from the RV32I field layout.
  function automatic logic [31:0] encode(input logic [3:0] op, input logic ui,
                                         input logic [4:0] d, input logic [4:0] s1,
                                         input logic [4:0] s2, input logic [11:0] im);
    logic [2:0] f3;
    logic [6:0] f7;
    f7 = (op == 4'd1 || op == 4'd9) ? 7'h20 : 7'h00;
    case (op)
      4'd7:       f3 = 3'd1;
      4'd2:       f3 = 3'd2;
      4'd3:       f3 = 3'd3;
      4'd4:       f3 = 3'd4;
      4'd8, 4'd9: f3 = 3'd5;
      4'd5:       f3 = 3'd6;
      4'd6:       f3 = 3'd7;
      default:    f3 = 3'd0;
    endcase
    if (!ui) return {f7, s2, s1, f3, d, 7'h33};
    if (op >= 4'd7) return {f7, im[4:0], s1, f3, d, 7'h13};
    return {im, s1, f3, d, 7'h13};
  endfunction

  function automatic bit is_legal(input logic [3:0] op, input logic ui);
    return (op < 4'd10) && !(op == 4'd1 && ui);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    test_count++;
    assert (obs === expv) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  // Drives one request for one cycle starting at posedge+1; returns whether
  // it was accepted and leaves time at the following posedge+1 with valid held.
  task automatic applyStimulus(input logic [3:0] op, input logic ui, input logic [4:0] d,
                               input logic [4:0] s1, input logic [4:0] s2,
                               input logic [11:0] im, output bit acc);
    exp_t e;
    alu_op    = op;
    use_imm   = ui;
    rd        = d;
    rs1       = s1;
    rs2       = s2;
    imm       = im;
    req_valid = 1'b1;
    @(negedge clk);
    acc = (req_ready === 1'b1);
    if (acc && is_legal(op, ui)) begin
      e.addr = ADDR_W'(model_count);
      e.data = encode(op, ui, d, s1, s2, im);
      sb_queue.push_back(e);
      model_count++;
    end
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every write must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    if (wr_en === 1'b1) begin
      if (sb_queue.size() == 0) begin
        checkOutput("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
      end else begin
        e = sb_queue.pop_front();
        checkOutput("sb_wr_addr", 32'(wr_addr), 32'(e.addr));
        checkOutput("sb_wr_data", wr_data, e.data);
      end
    end
  end

  initial begin
    bit         acc;
    logic [3:0]  op_tab[5]  = '{4'd7, 4'd4, 4'd3, 4'd8, 4'd6};
    logic        ui_tab[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [11:0] imm_tab[5] = '{12'h7FF, 12'h800, 12'h000, 12'h01F, 12'h000};

    // Asynchronous reset values
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_data", wr_data, 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_illegal", 32'(illegal), 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_ready", 32'(req_ready), 32'd0);

    // Start a program
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    model_count = 0;

    // ADD x1, x2, x3
    applyStimulus(4'd0, 1'b0, 5'd1, 5'd2, 5'd3, 12'h000, acc);
    req_valid = 1'b0;
    checkOutput("add_accept", 32'(acc), 32'd1);
    @(negedge clk);
    checkOutput("add_wr_en", 32'(wr_en), 32'd1);
    checkOutput("add_data", wr_data, 32'h003100B3);
    checkOutput("add_count", 32'(count), 32'd1);

    // SRAI x5, x6, 3 and the same with upper immediate bits set
    @(posedge clk); #1;
    applyStimulus(4'd9, 1'b1, 5'd5, 5'd6, 5'd0, 12'h003, acc);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("srai_data", wr_data, 32'h40335293);
    @(posedge clk); #1;
    applyStimulus(4'd9, 1'b1, 5'd5, 5'd6, 5'd0, 12'hFE3, acc);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("srai_hi_data", wr_data, 32'h40335293);
    checkOutput("srai_count", 32'(count), 32'd3);

    // SUB with immediate is illegal: accepted, dropped, flag set
    @(posedge clk); #1;
    applyStimulus(4'd1, 1'b1, 5'd7, 5'd8, 5'd0, 12'h005, acc);
    req_valid = 1'b0;
    checkOutput("subi_accept", 32'(acc), 32'd1);
    @(negedge clk);
    checkOutput("subi_wr_en", 32'(wr_en), 32'd0);
    checkOutput("subi_illegal", 32'(illegal), 32'd1);
    checkOutput("subi_count", 32'(count), 32'd3);
    @(posedge clk); #1;
    applyStimulus(4'd12, 1'b0, 5'd1, 5'd1, 5'd1, 12'h000, acc);
    req_valid = 1'b0;
    checkOutput("op12_accept", 32'(acc), 32'd1);
    @(negedge clk);
    checkOutput("op12_count", 32'(count), 32'd3);

    // Restart and fill to DEPTH with five back-to-back requests
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    model_count = 0;
    checkOutput("restart_illegal", 32'(illegal), 32'd0);
    checkOutput("restart_count", 32'(count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(op_tab[i], ui_tab[i], 5'(i + 1), 5'(i + 10), 5'(i + 20), imm_tab[i], acc);
      checkOutput($sformatf("fill_accept_%0d", i), 32'(acc), (i < DEPTH) ? 32'd1 : 32'd0);
    end
    repeat (3) begin
      @(negedge clk);
      checkOutput("full_ready", 32'(req_ready), 32'd0);
      checkOutput("full_flag", 32'(full), 32'd1);
      checkOutput("full_count", 32'(count), 32'd4);
    end

    // Start with a same-cycle request: request waits for the next cycle
    @(posedge clk); #1;
    alu_op    = 4'd0;
    use_imm   = 1'b0;
    rd        = 5'd10;
    rs1       = 5'd11;
    rs2       = 5'd12;
    start     = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    checkOutput("start_blocks_req", 32'(req_ready), 32'd0);
    @(posedge clk); #1 start = 1'b0;
    model_count = 0;
    checkOutput("start_count", 32'(count), 32'd0);
    checkOutput("start_not_full", 32'(full), 32'd0);
    applyStimulus(4'd0, 1'b0, 5'd10, 5'd11, 5'd12, 12'h000, acc);
    checkOutput("post_start_accept", 32'(acc), 32'd1);
    applyStimulus(4'd5, 1'b0, 5'd13, 5'd14, 5'd15, 12'h000, acc);

    // Reset mid-stream drops the in-flight write
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("midrst_ready", 32'(req_ready), 32'd0);
    checkOutput("midrst_count", 32'(count), 32'd0);
    sb_queue.delete();
    model_count = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_rst_ready", 32'(req_ready), 32'd0);
      checkOutput("post_rst_wr_en", 32'(wr_en), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    start     = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    applyStimulus(4'd2, 1'b0, 5'd3, 5'd4, 5'd5, 12'h000, acc);
    req_valid = 1'b0;
    checkOutput("post_rst_accept", 32'(acc), 32'd1);
    @(negedge clk);
    checkOutput("post_rst_addr", 32'(wr_addr), 32'd0);
    checkOutput("post_rst_count", 32'(count), 32'd1);

    repeat (2) @(posedge clk);
    checkOutput("sb_drained", 32'(sb_queue.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
